// File: rtl/game_tick_generator_pkg.sv
// game_tick_generator_pkg: shared GAME_STATE/GAME_SPEED encodings and speed-to-divisor mapping
package game_tick_generator_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT     = 2'b01,
    ST_PAUSE    = 2'b10,
    ST_END_GAME = 2'b11
  } game_state_e;
  typedef enum logic [1:0] {
    SPD_NORMAL = 2'b00,
    SPD_FAST   = 2'b01,
    SPD_SLOW   = 2'b10
  } game_speed_e;
  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_RUNNING,
    FSM_FROZEN
  } tick_fsm_e;
  localparam int unsigned NORMAL_DIV_DEF = 10_000_000;
  localparam int unsigned FAST_DIV_DEF   = 5_000_000;
  localparam int unsigned SLOW_DIV_DEF   = 20_000_000;
  // The unused 2'b11 code is treated as NORMAL everywhere.
  function automatic game_speed_e legal_speed(logic [1:0] raw);
    return raw == 2'b11 ? SPD_NORMAL : game_speed_e'(raw);
  endfunction
  function automatic int unsigned speed_div(game_speed_e sp,
                                            int unsigned normal_div = NORMAL_DIV_DEF,
                                            int unsigned fast_div   = FAST_DIV_DEF,
                                            int unsigned slow_div   = SLOW_DIV_DEF);
    return sp == SPD_FAST ? fast_div : sp == SPD_SLOW ? slow_div : normal_div;
  endfunction
endpackage

// File: rtl/game_tick_counter.sv
// game_tick_counter: loadable modulo counter with clear, hold and terminal-count flag
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : force count to 0 (highest priority)
//   load_i   : force count to 1 (the entry edge counts as the first edge of a period)
//   en_i     : advance; wraps to 0 after reaching last_i
//   last_i   : terminal value (period - 1)
//   tc_o     : count currently equals last_i
module game_tick_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    tc_o    = count_q == last_i;
    count_d = clr_i ? '0 : load_i ? W'(1) : en_i ? (tc_o ? '0 : count_q + W'(1)) : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
endmodule

// File: rtl/game_tick_generator.sv
// game_tick_generator: turns GAME_SPEED into a periodic one-cycle move_tick gated by GAME_STATE
//   system_clk, rst : clock, asynchronous active-high reset
//   state           : GAME_STATE (RUN/WAIT/PAUSE/END_GAME)
//   game_speed      : GAME_SPEED (NORMAL/FAST/SLOW, 11 treated as NORMAL)
//   move_tick       : registered one-cycle pulse per elapsed period
//   active_speed    : speed currently governing the period
//   tick_count      : ticks since the last WAIT, wraps at 256
module game_tick_generator
  import game_tick_generator_pkg::*;
#(
  parameter int unsigned NORMAL_DIV = NORMAL_DIV_DEF,
  parameter int unsigned FAST_DIV   = FAST_DIV_DEF,
  parameter int unsigned SLOW_DIV   = SLOW_DIV_DEF,
  parameter int unsigned CNT_W      = $clog2(SLOW_DIV)
) (
  input  logic       system_clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [1:0] game_speed,
  output logic       move_tick,
  output logic [1:0] active_speed,
  output logic [7:0] tick_count
);
  tick_fsm_e   fsm_q;
  game_state_e st;
  game_speed_e spd, active_speed_q;
  // period_q holds period-1 so that a power-of-two SLOW_DIV still fits in CNT_W bits.
  logic [CNT_W-1:0] period_q, spd_last;
  logic [7:0] tick_count_q;
  logic move_tick_q, tc, entry, step, tick, clr;
  always_comb begin
    st       = game_state_e'(state);
    spd      = legal_speed(game_speed);
    spd_last = CNT_W'(speed_div(spd, NORMAL_DIV, FAST_DIV, SLOW_DIV) - 1);
    entry    = st == ST_RUN && fsm_q == FSM_IDLE;
    step     = st == ST_RUN && fsm_q != FSM_IDLE;
    tick     = step && tc;
    clr      = st == ST_WAIT || st == ST_END_GAME;
  end
  game_tick_counter #(.W(CNT_W)) u_cnt (
    .clk    (system_clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (entry),
    .en_i   (step),
    .last_i (period_q),
    .tc_o   (tc)
  );
  always_ff @(posedge system_clk or posedge rst)
    if (rst) begin
      fsm_q          <= FSM_IDLE;
      period_q       <= CNT_W'(NORMAL_DIV - 1);
      active_speed_q <= SPD_NORMAL;
      move_tick_q    <= 1'b0;
      tick_count_q   <= '0;
    end else begin
      fsm_q          <= clr ? FSM_IDLE : st == ST_PAUSE ? (fsm_q == FSM_IDLE ? FSM_IDLE : FSM_FROZEN) : FSM_RUNNING;
      move_tick_q    <= tick;
      tick_count_q   <= st == ST_WAIT ? '0 : tick ? tick_count_q + 8'd1 : tick_count_q;
      period_q       <= entry || tick ? spd_last : period_q;
      // New speed only takes effect at a period boundary; WAIT mirrors the live menu choice.
      active_speed_q <= entry || tick || st == ST_WAIT ? spd : active_speed_q;
    end
  assign move_tick    = move_tick_q;
  assign active_speed = active_speed_q;
  assign tick_count   = tick_count_q;
endmodule

// File: tb/tb_game_tick_generator.sv
// tb_game_tick_generator: directed vector bench for game_tick_generator (NORMAL=4, FAST=2, SLOW=8)
module tb_game_tick_generator;
  localparam logic [1:0] RUN = 2'b00, WAIT = 2'b01, PAUSE = 2'b10, ENDG = 2'b11;
  localparam logic [1:0] NRM = 2'b00, FST = 2'b01, SLW = 2'b10, ILL = 2'b11;
  typedef struct {
    logic [1:0] st;
    logic [1:0] sp;
    logic       t;
    logic [1:0] a;
    logic [7:0] c;
  } vec_t;
  logic system_clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state = WAIT;
  logic [1:0] game_speed = NRM;
  logic move_tick;
  logic [1:0] active_speed;
  logic [7:0] tick_count;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  game_tick_generator #(.NORMAL_DIV(4), .FAST_DIV(2), .SLOW_DIV(8)) dut (
    .system_clk   (system_clk),
    .rst          (rst),
    .state        (state),
    .game_speed   (game_speed),
    .move_tick    (move_tick),
    .active_speed (active_speed),
    .tick_count   (tick_count)
  );
  always #5 system_clk = ~system_clk;
  task automatic check(string nm, logic t, logic [1:0] a, logic [7:0] c);
    n_vec++;
    if (move_tick !== t || active_speed !== a || tick_count !== c) begin
      n_bad++;
      $display("FAIL %s: got tick=%b spd=%0d cnt=%0d, want tick=%b spd=%0d cnt=%0d",
               nm, move_tick, active_speed, tick_count, t, a, c);
    end
  endtask
  task automatic step(string nm, logic [1:0] st, logic [1:0] sp, logic t, logic [1:0] a, logic [7:0] c);
    state = st;
    game_speed = sp;
    @(posedge system_clk);
    #1;
    check(nm, t, a, c);
  endtask
  function automatic void add(logic [1:0] st, logic [1:0] sp, logic t, logic [1:0] a, logic [7:0] c);
    tbl.push_back('{st, sp, t, a, c});
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 1; i <= 12; i++) add(RUN, NRM, i % 4 == 0, NRM, 8'(i / 4));
    add(WAIT, SLW, 1'b0, SLW, 8'd0);
    for (int i = 1; i <= 11; i++) add(RUN, SLW, i == 8, SLW, 8'(i >= 8));
    for (int i = 12; i <= 20; i++)
      add(RUN, FST, i == 16 || i == 18 || i == 20, i >= 16 ? FST : SLW,
          8'(1 + int'(i >= 16) + int'(i >= 18) + int'(i >= 20)));
    add(WAIT, ILL, 1'b0, NRM, 8'd0);
    for (int i = 1; i <= 8; i++) add(RUN, ILL, i % 4 == 0, NRM, 8'(i / 4));
    repeat (2) @(posedge system_clk);
    #1;
    check("reset", 1'b0, NRM, 8'd0);
    rst = 1'b0;
    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sp, tbl[i].t, tbl[i].a, tbl[i].c);
    step("pause_wait", WAIT, NRM, 1'b0, NRM, 8'd0);
    for (int i = 1; i <= 4; i++) step("pause_pre", RUN, NRM, i == 4, NRM, 8'(i == 4));
    repeat (2) step("pause_cnt2", RUN, NRM, 1'b0, NRM, 8'd1);
    repeat (10) step("paused", PAUSE, FST, 1'b0, NRM, 8'd1);
    step("resume1", RUN, NRM, 1'b0, NRM, 8'd1);
    step("resume2", RUN, NRM, 1'b1, NRM, 8'd2);
    repeat (3) step("bnd_run", RUN, NRM, 1'b0, NRM, 8'd2);
    step("bnd_pause", PAUSE, NRM, 1'b0, NRM, 8'd2);
    step("bnd_resume", RUN, NRM, 1'b1, NRM, 8'd3);
    step("w_wait", WAIT, NRM, 1'b0, NRM, 8'd0);
    for (int i = 1; i <= 20; i++) step("w_run", RUN, NRM, i % 4 == 0, NRM, 8'(i / 4));
    step("w_clear", WAIT, NRM, 1'b0, NRM, 8'd0);
    step("w_fast", WAIT, FST, 1'b0, FST, 8'd0);
    step("w_slow", WAIT, SLW, 1'b0, SLW, 8'd0);
    step("w_ill", WAIT, ILL, 1'b0, NRM, 8'd0);
    for (int i = 1; i <= 12; i++) step("e_run", RUN, NRM, i % 4 == 0, NRM, 8'(i / 4));
    repeat (20) step("e_hold", ENDG, SLW, 1'b0, NRM, 8'd3);
    for (int i = 1; i <= 4; i++) step("e_restart", RUN, NRM, i == 4, NRM, 8'(i == 4 ? 4 : 3));
    step("r_wait", WAIT, FST, 1'b0, FST, 8'd0);
    step("r_entry", RUN, FST, 1'b0, FST, 8'd0);
    step("r_tick", RUN, FST, 1'b1, FST, 8'd1);
    #2 rst = 1'b1;
    #1 check("async_rst", 1'b0, NRM, 8'd0);
    @(posedge system_clk);
    #1;
    check("rst_hold", 1'b0, NRM, 8'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) step("post_rst", RUN, NRM, i == 4, NRM, 8'(i == 4));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
